commit_trace_buffer: RTL and testbench
======================================

# commit_trace_buffer

Sits on the commit side of the out-of-order core and turns each retirement into a buffered commit record (pc, destination register, write data) for the lockstep ISA checker. The checker consumes records through a valid/ready handshake instead of a gated clock, so the core never stalls on the checker. The block also flags lost records and commit starvation as sticky error bits for formal properties.

## Interface

Parameters:
- `PC_W`, 8: pc width.
- `RF_ADDR_W`, 2: register index width.
- `DATA_W`, 8: register data width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `WDOG_LIMIT`, 10: cycles without a commit before timeout.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `commit_valid`, in, 1: core retires one instruction this cycle.
- `commit_pc`, in, PC_W: pc of the retiring instruction.
- `commit_wen`, in, 1: the instruction writes the register file.
- `commit_rd`, in, RF_ADDR_W: destination register.
- `commit_data`, in, DATA_W: value written.
- `out_valid`, out, 1: head record available.
- `out_ready`, in, 1: checker accepts the head record.
- `out_pc`, `out_wen`, `out_rd`, `out_data`, out, matching widths: head record fields.
- `count`, out, $clog2(DEPTH)+1: occupancy.
- `full`, out, 1: count == DEPTH.
- `overflow`, out, 1: sticky; a commit was dropped.
- `wdog_timeout`, out, 1: sticky; commit starvation (see Configuration).

## Operation

- Storage is a circular FIFO with read pointer `rd_ptr`, write pointer `wr_ptr` (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and a separate `count` register.
- Dequeue: when `out_valid && out_ready`, `rd_ptr` increments.
- Enqueue: when `commit_valid` and (`!full` or a dequeue happens the same cycle), the record is written at `wr_ptr` and `wr_ptr` increments.
- `count` update: +1 on enqueue only, −1 on dequeue only, unchanged when both or neither occur.
- Full drop: if `commit_valid && full && !(out_valid && out_ready)`, the record is discarded, pointers and `count` are unchanged, and `overflow` sets.
- Outputs:
  - `out_valid = (count != 0)`.
  - The `out_*` fields are read combinationally from the entry at `rd_ptr`.
  - While `out_valid` = 0, the `out_*` field values are don't-care.
- Handshake: once `out_valid` is high, the head fields hold stable until accepted.
- `out_wen` = 0 records (branches, stores) are still queued, so the checker steps its pc on every commit.
- No bypass. A commit presented while the FIFO is empty appears on the outputs the next cycle.
- Error flags `overflow` and `wdog_timeout` clear only on `rst`.

## Timing

- Reset values:
  - Pointers, `count`, `overflow`, `wdog_timeout`, watchdog counter all 0.
  - `out_valid` 0, `full` 0.
  - Storage contents are not reset.
- Latency: 1 cycle from the `commit_valid` edge to `out_valid`. Throughput is one record per cycle in each direction.
- Wrap-around: pointers roll over from DEPTH−1 to 0 with no bubble.
- Simultaneous enqueue/dequeue:
  - When full, the freed slot is reused the same cycle; `count` stays DEPTH and no overflow occurs.
  - When empty, no dequeue can occur (`out_valid` = 0), so the cycle is a plain enqueue.
- Reset asserted mid-operation empties the FIFO immediately and asynchronously. In-flight records are lost, with no overflow flag.

## Configuration

- Macro: `COMMIT_TRACE_WDOG_EN`.
- Defined:
  - An up-counter ($clog2(WDOG_LIMIT+1) bits) clears on any cycle with `commit_valid`, otherwise increments, saturating at WDOG_LIMIT.
  - `wdog_timeout` sets on the cycle the counter reaches WDOG_LIMIT, i.e. after WDOG_LIMIT consecutive commit-free cycles after reset or after the last commit.
  - Once set, it remains set.
- Undefined: no counter is built and `wdog_timeout` is tied to 0.

## Test plan

- Reset, then commit pc=0x04 rd=1 data=0x2A wen=1 with `out_ready`=0:
  - Next cycle `out_valid`=1 and `out_*` show the record; `count`=1.
  - Record holds for 5 cycles, then `out_ready`=1 for 1 cycle gives `count`=0 and `out_valid`=0.
- 4 back-to-back commits (pc 0x00–0x03, `out_ready`=0, DEPTH=4):
  - `full`=1, `count`=4.
  - A fifth commit sets `overflow`=1, and pc 0x00–0x03 still drain in order.
- Full FIFO with `out_ready`=1 and `commit_valid`=1 for 6 cycles:
  - `count` stays 4, no overflow.
  - Output pc sequence is continuous across pointer wrap.
- Commit with `commit_wen`=0, pc=0x10: a record is queued with `out_wen`=0 and `out_pc`=0x10.
- With `COMMIT_TRACE_WDOG_EN`, 9 idle cycles then 1 commit, then 10 idle cycles:
  - No timeout after the first 9.
  - `wdog_timeout`=1 on the 10th idle cycle; it stays 1 after later commits.
  - Without the macro, `wdog_timeout` stays 0.
- Assert `rst` asynchronously while `count`=3: `count`=0, `out_valid`=0 and flags 0 before the next clock edge.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit-side trace FIFO feeding the lockstep ISA checker over a valid/ready handshake.
// Optional commit-starvation watchdog is built when COMMIT_TRACE_WDOG_EN is defined.
module commit_trace_buffer #(
    parameter int PC_W       = 8,
    parameter int RF_ADDR_W  = 2,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int WDOG_LIMIT = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [PC_W-1:0]          commit_pc,
    input  logic                     commit_wen,
    input  logic [RF_ADDR_W-1:0]     commit_rd,
    input  logic [DATA_W-1:0]        commit_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic                     out_wen,
    output logic [RF_ADDR_W-1:0]     out_rd,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic                     wdog_timeout
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = PC_W + 1 + RF_ADDR_W + DATA_W;

    logic [REC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             deq, enq;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign {out_pc, out_wen, out_rd, out_data} = mem[rd_ptr_q];

    always_comb begin
        deq = out_valid && out_ready;
        // A dequeue in the same cycle frees the head slot, so a full FIFO can still accept.
        enq = commit_valid && (!full || deq);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (commit_valid && !enq);
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr_q] <= {commit_pc, commit_wen, commit_rd, commit_data};
    end

`ifdef COMMIT_TRACE_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_timeout_q, wdog_timeout_d;

    always_comb begin
        if (commit_valid)               wdog_cnt_d = '0;
        else if (wdog_cnt_q == WDOG_MAX) wdog_cnt_d = wdog_cnt_q;
        else                            wdog_cnt_d = wdog_cnt_q + 1'b1;
        wdog_timeout_d = wdog_timeout_q | (wdog_cnt_d == WDOG_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q     <= '0;
            wdog_timeout_q <= 1'b0;
        end else begin
            wdog_cnt_q     <= wdog_cnt_d;
            wdog_timeout_q <= wdog_timeout_d;
        end
    end

    assign wdog_timeout = wdog_timeout_q;
`else
    assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: queue-based reference model plus directed
// literal checks from the commit-trace test plan, followed by randomized traffic.
module tb_commit_trace_buffer;
    localparam int PC_W = 8, RF_ADDR_W = 2, DATA_W = 8, DEPTH = 4, WDOG_LIMIT = 10;
    localparam int REC_W = PC_W + 1 + RF_ADDR_W + DATA_W;
`ifdef COMMIT_TRACE_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 commit_valid = 1'b0;
    logic [PC_W-1:0]      commit_pc = '0;
    logic                 commit_wen = 1'b0;
    logic [RF_ADDR_W-1:0] commit_rd = '0;
    logic [DATA_W-1:0]    commit_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [PC_W-1:0]      out_pc;
    logic                 out_wen;
    logic [RF_ADDR_W-1:0] out_rd;
    logic [DATA_W-1:0]    out_data;
    logic [$clog2(DEPTH):0] count;
    logic                 full, overflow, wdog_timeout;

    int checks = 0;
    int failures = 0;

    commit_trace_buffer #(
        .PC_W(PC_W), .RF_ADDR_W(RF_ADDR_W), .DATA_W(DATA_W),
        .DEPTH(DEPTH), .WDOG_LIMIT(WDOG_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_wen(commit_wen),
        .commit_rd(commit_rd), .commit_data(commit_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_wen(out_wen), .out_rd(out_rd), .out_data(out_data),
        .count(count), .full(full), .overflow(overflow), .wdog_timeout(wdog_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of records, a sticky drop flag and an idle-run length.
    logic [REC_W-1:0] mq[$];
    bit               m_ovf = 1'b0;
    bit               m_to = 1'b0;
    int               m_idle = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_to   = 1'b0;
            m_idle = 0;
        end else begin
            bit deq, enq;
            deq = (mq.size() != 0) && out_ready;
            enq = commit_valid && ((mq.size() < DEPTH) || deq);
            if (commit_valid && !enq) m_ovf = 1'b1;
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back({commit_pc, commit_wen, commit_rd, commit_data});
            if (commit_valid) m_idle = 0;
            else if (m_idle < WDOG_LIMIT) m_idle++;
            if (WDOG_ON && m_idle >= WDOG_LIMIT) m_to = 1'b1;
        end
    end

    logic [REC_W-1:0] head_rec;
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("count", 32'(count), 32'(mq.size()));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("wdog_timeout", 32'(wdog_timeout), 32'(m_to));
            if (mq.size() != 0) begin
                head_rec = mq[0];
                chk("out_rec", 32'({out_pc, out_wen, out_rd, out_data}), 32'(head_rec));
            end
        end
    end

    task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic wen,
                        input logic [RF_ADDR_W-1:0] rd, input logic [DATA_W-1:0] d,
                        input logic rdy);
        commit_valid = v;
        commit_pc    = pc;
        commit_wen   = wen;
        commit_rd    = rd;
        commit_data  = d;
        out_ready    = rdy;
        @(posedge clk);
        @(negedge clk);
        $display("txn t=%0t v=%0b pc=%02h rdy=%0b -> ov=%0b opc=%02h cnt=%0d full=%0b ovf=%0b wdog=%0b",
                 $time, v, pc, rdy, out_valid, out_pc, count, full, overflow, wdog_timeout);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, rdy);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_count", 32'(count), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_full", 32'(full), 0);
        chk("reset_overflow", 32'(overflow), 0);

        // Watchdog: 9 idle, commit, 10 idle.
        idle(9, 1'b1);
        chk("wdog_after_9", 32'(wdog_timeout), 0);
        step(1'b1, 8'h50, 1'b1, 2'd0, 8'h00, 1'b1);
        idle(9, 1'b1);
        chk("wdog_idle_9", 32'(wdog_timeout), 0);
        idle(1, 1'b1);
        chk("wdog_idle_10", 32'(wdog_timeout), 32'(WDOG_ON));
        step(1'b1, 8'h51, 1'b1, 2'd0, 8'h00, 1'b1);
        idle(1, 1'b1);
        chk("wdog_sticky", 32'(wdog_timeout), 32'(WDOG_ON));
        chk("wdog_empty", 32'(count), 0);

        // Single record holds until accepted.
        step(1'b1, 8'h04, 1'b1, 2'd1, 8'h2A, 1'b0);
        chk("one_valid", 32'(out_valid), 1);
        chk("one_pc", 32'(out_pc), 32'h04);
        chk("one_rd", 32'(out_rd), 1);
        chk("one_data", 32'(out_data), 32'h2A);
        chk("one_wen", 32'(out_wen), 1);
        chk("one_count", 32'(count), 1);
        idle(5, 1'b0);
        chk("hold_pc", 32'(out_pc), 32'h04);
        chk("hold_data", 32'(out_data), 32'h2A);
        idle(1, 1'b1);
        chk("accept_count", 32'(count), 0);
        chk("accept_valid", 32'(out_valid), 0);

        // Fill, overflow, drain in order.
        for (int i = 0; i < 4; i++) step(1'b1, PC_W'(i), 1'b1, 2'(i), 8'(8'h10 + i), 1'b0);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 4);
        chk("fill_no_ovf", 32'(overflow), 0);
        step(1'b1, 8'h99, 1'b1, 2'd3, 8'hEE, 1'b0);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_count", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 32'(out_pc), 32'(i));
            idle(1, 1'b1);
        end
        chk("drain_empty", 32'(out_valid), 0);

        // Full with simultaneous enqueue/dequeue across pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, PC_W'(8'h20 + i), 1'b1, 2'd2, 8'(i), 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("wrap_pc", 32'(out_pc), 32'(8'h20 + i));
            step(1'b1, PC_W'(8'h24 + i), 1'b1, 2'd2, 8'(4 + i), 1'b1);
            chk("wrap_count", 32'(count), 4);
        end
        for (int i = 0; i < 4; i++) begin
            chk("wrap_drain_pc", 32'(out_pc), 32'(8'h26 + i));
            idle(1, 1'b1);
        end

        // Non-writing commit is still queued.
        step(1'b1, 8'h10, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("nowen_wen", 32'(out_wen), 0);
        chk("nowen_pc", 32'(out_pc), 32'h10);
        idle(1, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 6), PC_W'($urandom), 1'($urandom),
                 RF_ADDR_W'($urandom), DATA_W'($urandom), 1'($urandom));

        // Asynchronous reset with three records in flight.
        idle(DEPTH + 1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, PC_W'(8'h60 + i), 1'b1, 2'd1, 8'h00, 1'b0);
        chk("pre_rst_count", 32'(count), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_overflow", 32'(overflow), 0);
        chk("arst_wdog", 32'(wdog_timeout), 0);
        chk("arst_full", 32'(full), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 100; i++)
            step(($urandom_range(0, 9) < 7), PC_W'($urandom), 1'($urandom),
                 RF_ADDR_W'($urandom), DATA_W'($urandom), ($urandom_range(0, 9) < 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
